// File: rtl/medidor_frecuencia.sv
// medidor_frecuencia: gated frequency meter.
// Counts synchronized rising edges of senalEntrada over a window of
// GATE_CYCLES clkNexys2 cycles and publishes the count with a one-cycle
// listo pulse. The edge counter saturates and flags desborde.
module medidor_frecuencia #(
    parameter int GATE_CYCLES = 50_000_000,
    parameter int GATE_W      = 26,
    parameter int FREQ_W      = 26
) (
    input  logic              clkNexys2,
    input  logic              Reset,
    input  logic              habilitar,
    input  logic              senalEntrada,
    output logic [FREQ_W-1:0] frecuencia,
    output logic              desborde,
    output logic              listo
);

    typedef enum logic {
        DETENIDO = 1'b0,
        MIDIENDO = 1'b1
    } estado_t;

    localparam logic [GATE_W-1:0] G_ULTIMO = GATE_W'(GATE_CYCLES - 1);
    localparam logic [FREQ_W-1:0] E_MAX    = '1;

    estado_t r_estado;
    estado_t w_estado_sig;

    logic r_sinc1;
    logic r_sinc2;
    logic r_prev;
    logic w_flanco;

    logic [GATE_W-1:0] r_g;
    logic [FREQ_W-1:0] r_e;
    logic              r_sat;

    logic [GATE_W-1:0] w_g_base;
    logic [FREQ_W-1:0] w_e_base;
    logic              w_sat_base;
    logic              w_cerrar;
    logic              w_tope;
    logic [FREQ_W-1:0] w_e_inc;

    // Two-flop synchronizer plus previous-value flop for edge detection
    always_ff @(posedge clkNexys2) begin
        if (Reset) begin
            r_sinc1 <= 1'b0;
            r_sinc2 <= 1'b0;
            r_prev  <= 1'b0;
        end else begin
            r_sinc1 <= senalEntrada;
            r_sinc2 <= r_sinc1;
            r_prev  <= r_sinc2;
        end
    end

    assign w_flanco = r_sinc2 & ~r_prev;

    // State register: measuring or stopped
    always_ff @(posedge clkNexys2) begin
        if (Reset) begin
            r_estado <= DETENIDO;
        end else begin
            r_estado <= w_estado_sig;
        end
    end

    // Next state follows the enable directly
    always_comb begin
        w_estado_sig = DETENIDO;
        if (habilitar) begin
            w_estado_sig = MIDIENDO;
        end
    end

    // Window control: counters are only trusted while already measuring,
    // so the first enabled cycle after a stop or reset starts from zero
    always_comb begin
        w_g_base   = '0;
        w_e_base   = '0;
        w_sat_base = 1'b0;
        if (r_estado == MIDIENDO) begin
            w_g_base   = r_g;
            w_e_base   = r_e;
            w_sat_base = r_sat;
        end
        w_cerrar = habilitar && (w_g_base == G_ULTIMO);
        w_tope   = w_flanco && (w_e_base == E_MAX);
        w_e_inc  = w_e_base;
        if (w_flanco && !w_tope) begin
            w_e_inc = w_e_base + FREQ_W'(1'b1);
        end
    end

    // Gate/edge counters and result publication.
    // While stopped the counters simply hold; the DETENIDO state masks them
    // to zero on re-enable, equivalent to clearing them every stopped cycle.
    always_ff @(posedge clkNexys2) begin
        if (Reset) begin
            r_g        <= '0;
            r_e        <= '0;
            r_sat      <= 1'b0;
            frecuencia <= '0;
            desborde   <= 1'b0;
            listo      <= 1'b0;
        end else begin
            listo <= 1'b0;
            if (w_cerrar) begin
                frecuencia <= w_e_inc;
                desborde   <= w_sat_base | w_tope;
                listo      <= 1'b1;
                r_g        <= '0;
                r_e        <= '0;
                r_sat      <= 1'b0;
            end else if (habilitar) begin
                r_g   <= w_g_base + GATE_W'(1'b1);
                r_e   <= w_e_inc;
                r_sat <= w_sat_base | w_tope;
            end
        end
    end

endmodule

// File: tb/tb_medidor_frecuencia.sv
// tb_medidor_frecuencia: randomized and directed checks of the frequency
// meter against a cycle-level reference model (window of 100 cycles,
// 4-bit result so saturation is easy to reach).
module tb_medidor_frecuencia;

    localparam int VENTANA = 100;
    localparam int MAXCNT  = 15;

    logic       clkNexys2 = 1'b0;
    logic       Reset = 1'b1;
    logic       habilitar = 1'b0;
    logic       senalEntrada = 1'b0;
    logic [3:0] frecuencia;
    logic       desborde;
    logic       listo;

    int n_checks = 0;
    int n_errors = 0;
    int fase = 0;

    // Reference model state
    bit hist[$];
    int m_len = 0;
    int m_edges = 0;
    int m_f = 0;
    int m_d = 0;
    int m_l = 0;

    medidor_frecuencia #(
        .GATE_CYCLES(VENTANA),
        .GATE_W     (7),
        .FREQ_W     (4)
    ) dut (
        .clkNexys2   (clkNexys2),
        .Reset       (Reset),
        .habilitar   (habilitar),
        .senalEntrada(senalEntrada),
        .frecuencia  (frecuencia),
        .desborde    (desborde),
        .listo       (listo)
    );

    always #5 clkNexys2 = ~clkNexys2;

    task automatic chequear(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, advance the model, compare outputs.
    // Model: an input value sampled at edge t is seen as a rising edge at
    // edge t+2 if the value sampled one cycle earlier was low.
    task automatic ciclo(input logic rst, input logic hab, input logic sig);
        bit flanco;
        @(negedge clkNexys2);
        Reset        = rst;
        habilitar    = hab;
        senalEntrada = sig;
        @(posedge clkNexys2);
        if (rst) begin
            m_len = 0; m_edges = 0; m_f = 0; m_d = 0; m_l = 0;
            hist = '{1'b0, 1'b0, 1'b0};
        end else begin
            flanco = hist[1] && !hist[0];
            if (!hab) begin
                m_len = 0; m_edges = 0; m_l = 0;
            end else begin
                m_edges += int'(flanco);
                m_len++;
                if (m_len == VENTANA) begin
                    m_f = (m_edges > MAXCNT) ? MAXCNT : m_edges;
                    m_d = (m_edges > MAXCNT) ? 1 : 0;
                    m_l = 1;
                    m_len = 0;
                    m_edges = 0;
                end else begin
                    m_l = 0;
                end
            end
            hist.push_back(sig);
            void'(hist.pop_front());
        end
        #1;
        chequear("listo", 32'(listo), 32'(m_l));
        chequear("frecuencia", 32'(frecuencia), 32'(m_f));
        chequear("desborde", 32'(desborde), 32'(m_d));
    endtask

    task automatic onda(input int periodo, input int n, input logic hab);
        for (int i = 0; i < n; i++) begin
            ciclo(1'b0, hab, ((fase % periodo) < (periodo / 2)));
            fase++;
        end
    endtask

    task automatic constante(input logic v, input int n, input logic hab);
        for (int i = 0; i < n; i++) begin
            ciclo(1'b0, hab, v);
        end
    endtask

    initial begin
        hist = '{1'b0, 1'b0, 1'b0};

        // Reset state
        ciclo(1'b1, 1'b0, 1'b0);
        ciclo(1'b1, 1'b0, 1'b0);
        chequear("rst_frecuencia", 32'(frecuencia), 32'd0);
        chequear("rst_listo", 32'(listo), 32'd0);

        // Period 10 square wave: 10 edges per window after the first
        onda(10, 350, 1'b1);
        chequear("p10_frecuencia", 32'(frecuencia), 32'd10);
        chequear("p10_desborde", 32'(desborde), 32'd0);

        // Period 4: 25 edges saturate the 4-bit counter
        onda(4, 300, 1'b1);
        chequear("sat_frecuencia", 32'(frecuencia), 32'd15);
        chequear("sat_desborde", 32'(desborde), 32'd1);

        // Period 20 recovers: 5 edges, no overflow
        onda(20, 300, 1'b1);
        chequear("p20_frecuencia", 32'(frecuencia), 32'd5);
        chequear("p20_desborde", 32'(desborde), 32'd0);

        // Input held low
        constante(1'b0, 250, 1'b1);
        chequear("cero_frecuencia", 32'(frecuencia), 32'd0);

        // Input high from reset release: first window reads 1, later 0
        ciclo(1'b1, 1'b0, 1'b0);
        constante(1'b1, VENTANA, 1'b1);
        chequear("alto_primera_listo", 32'(listo), 32'd1);
        chequear("alto_primera_frec", 32'(frecuencia), 32'd1);
        constante(1'b1, VENTANA, 1'b1);
        chequear("alto_segunda_frec", 32'(frecuencia), 32'd0);

        // Enable dropped at cycle 50 for 30 cycles
        ciclo(1'b1, 1'b0, 1'b0);
        fase = 0;
        onda(10, 50, 1'b1);
        onda(10, 30, 1'b0);
        onda(10, VENTANA - 1, 1'b1);
        chequear("reen_previo", 32'(listo), 32'd0);
        onda(10, 1, 1'b1);
        chequear("reen_listo", 32'(listo), 32'd1);

        // One-cycle reset mid-window
        onda(10, 40, 1'b1);
        ciclo(1'b1, 1'b1, 1'b0);
        chequear("rstmid_frecuencia", 32'(frecuencia), 32'd0);
        chequear("rstmid_desborde", 32'(desborde), 32'd0);
        chequear("rstmid_listo", 32'(listo), 32'd0);
        onda(10, VENTANA - 1, 1'b1);
        chequear("rstmid_previo", 32'(listo), 32'd0);
        onda(10, 1, 1'b1);
        chequear("rstmid_sig_listo", 32'(listo), 32'd1);

        // Single edge detected on the closing cycle of the window
        ciclo(1'b1, 1'b0, 1'b0);
        constante(1'b0, VENTANA - 3, 1'b1);
        constante(1'b1, 3, 1'b1);
        chequear("cierre_listo", 32'(listo), 32'd1);
        chequear("cierre_frecuencia", 32'(frecuencia), 32'd1);
        constante(1'b1, VENTANA, 1'b1);
        chequear("cierre_siguiente", 32'(frecuencia), 32'd0);

        // Randomized segments
        for (int s = 0; s < 40; s++) begin
            int modo;
            int largo;
            modo  = int'($urandom_range(0, 4));
            largo = int'($urandom_range(20, 300));
            case (modo)
                0, 1: onda(int'($urandom_range(2, 16)), largo, 1'b1);
                2: begin
                    for (int i = 0; i < largo; i++) begin
                        ciclo(1'b0, 1'b1, 1'($urandom_range(0, 1)));
                    end
                end
                3: onda(int'($urandom_range(2, 16)), int'($urandom_range(1, 60)), 1'b0);
                default: ciclo(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            endcase
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
